// File: rtl/ttt_pkg.sv
// Shared constants, line tables and FSM state type for the tic-tac-toe controller.
// CELL_LINES / CELL_LINE_CNT are only consulted when TTT_FAST_SCAN_EN is defined.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  // Lines through each cell in ascending order; unused slots padded with 0.
  localparam logic [2:0] CELL_LINES [NUM_CELLS][4] = '{
    '{3'd0, 3'd3, 3'd6, 3'd0}, '{3'd0, 3'd4, 3'd0, 3'd0}, '{3'd0, 3'd5, 3'd7, 3'd0},
    '{3'd1, 3'd3, 3'd0, 3'd0}, '{3'd1, 3'd4, 3'd6, 3'd7}, '{3'd1, 3'd5, 3'd0, 3'd0},
    '{3'd2, 3'd3, 3'd7, 3'd0}, '{3'd2, 3'd4, 3'd0, 3'd0}, '{3'd2, 3'd5, 3'd6, 3'd0}
  };

  localparam logic [2:0] CELL_LINE_CNT [NUM_CELLS] = '{
    3'd3, 3'd2, 3'd3, 3'd2, 3'd4, 3'd2, 3'd3, 3'd2, 3'd3
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_X) ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/pos_win.sv
// Single three-in-a-row checker: returns the common player code when all three
// cells hold the same non-empty value, otherwise empty.
module pos_win (
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  output logic [1:0] win
);

  assign win = ((pos1 != 2'b00) && (pos1 == pos2) && (pos2 == pos3)) ? pos1 : 2'b00;

endmodule

// File: rtl/ttt_line_mux.sv
// Selects the three cells of one winning line from the packed board so that a
// single pos_win checker can be shared across all lines.
module ttt_line_mux
  import ttt_pkg::*;
(
  input  logic [17:0] board_i,
  input  logic [2:0]  line_idx_i,
  output logic [1:0]  pos1_o,
  output logic [1:0]  pos2_o,
  output logic [1:0]  pos3_o
);

  always_comb begin
    pos1_o = CELL_EMPTY;
    pos2_o = CELL_EMPTY;
    pos3_o = CELL_EMPTY;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (LINE_CELLS[line_idx_i][0] == 4'(c)) pos1_o = board_i[2*c +: 2];
      if (LINE_CELLS[line_idx_i][1] == 4'(c)) pos2_o = board_i[2*c +: 2];
      if (LINE_CELLS[line_idx_i][2] == 4'(c)) pos3_o = board_i[2*c +: 2];
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: takes moves, scans winning lines one per clock.
// Define TTT_FAST_SCAN_EN to scan only the lines through the last-played cell.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER    = 2'b01,
  parameter bit         ALTERNATE_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  output logic        move_ready,
  output logic        move_accept,
  output logic        move_reject,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic        scan_busy,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw
);

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  turn_q, turn_d;
  logic [1:0]  start_q, start_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  winner_q, winner_d;
  logic        draw_q, draw_d;
  logic        accept_q, accept_d;
  logic        reject_q, reject_d;
  logic [2:0]  step_q, step_d;
`ifdef TTT_FAST_SCAN_EN
  logic [3:0]  last_q, last_d;
`endif

  logic [2:0] line_idx;
  logic       last_step;
  logic [1:0] pos1, pos2, pos3, line_win;
  logic       cell_free;

`ifdef TTT_FAST_SCAN_EN
  always_comb begin
    line_idx  = CELL_LINES[last_q][step_q[1:0]];
    last_step = (step_q == (CELL_LINE_CNT[last_q] - 3'd1));
  end
`else
  always_comb begin
    line_idx  = step_q;
    last_step = (step_q == 3'd7);
  end
`endif

  ttt_line_mux u_line_mux (
    .board_i    (board_q),
    .line_idx_i (line_idx),
    .pos1_o     (pos1),
    .pos2_o     (pos2),
    .pos3_o     (pos3)
  );

  pos_win u_pos_win (
    .pos1 (pos1),
    .pos2 (pos2),
    .pos3 (pos3),
    .win  (line_win)
  );

  // Out-of-range positions never match a cell, so they read as occupied.
  always_comb begin
    cell_free = 1'b0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (move_pos == 4'(c)) cell_free = (board_q[2*c +: 2] == CELL_EMPTY);
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    start_d  = start_q;
    count_d  = count_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    step_d   = step_q;
`ifdef TTT_FAST_SCAN_EN
    last_d   = last_q;
`endif

    if (new_game) begin
      board_d  = '0;
      count_d  = '0;
      winner_d = CELL_EMPTY;
      draw_d   = 1'b0;
      step_d   = '0;
      state_d  = ST_IDLE;
      if (ALTERNATE_START) start_d = other_player(start_q);
      turn_d   = start_d;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (move_valid) begin
            if (cell_free) begin
              for (int c = 0; c < NUM_CELLS; c++) begin
                if (move_pos == 4'(c)) board_d[2*c +: 2] = turn_q;
              end
              count_d  = count_q + 4'd1;
              accept_d = 1'b1;
              step_d   = '0;
              state_d  = ST_SCAN;
`ifdef TTT_FAST_SCAN_EN
              last_d   = move_pos;
`endif
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (line_win != CELL_EMPTY) begin
            winner_d = line_win;
            state_d  = ST_DONE;
          end else if (last_step) begin
            if (count_q == 4'd9) begin
              draw_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              turn_d  = other_player(turn_q);
              state_d = ST_IDLE;
            end
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      board_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      start_q  <= FIRST_PLAYER;
      count_q  <= '0;
      winner_q <= CELL_EMPTY;
      draw_q   <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      step_q   <= '0;
`ifdef TTT_FAST_SCAN_EN
      last_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      start_q  <= start_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      step_q   <= step_d;
`ifdef TTT_FAST_SCAN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign move_ready  = (state_q == ST_IDLE);
  assign scan_busy   = (state_q == ST_SCAN);
  assign game_over   = (state_q == ST_DONE);
  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign board       = board_q;
  assign turn        = turn_q;
  assign winner      = winner_q;
  assign draw        = draw_q;

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Sequencing controller for one tic-tac-toe game. It accepts player moves over a valid/ready handshake, keeps the 9-cell board register, and time-multiplexes one shared pos_win line checker across the 8 winning lines, one line per clock. It reports win or draw, alternates turns, and rejects illegal moves. It sits between the move-input front end and the display/scoreboard logic.

Parameters:
- FIRST_PLAYER, 2'b01: cell code of the player who moves first after reset (2'b01 = X, 2'b10 = O).
- ALTERNATE_START, 1: when 1, each new_game swaps the starting player relative to the previous game; when 0, every game starts with FIRST_PLAYER.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- new_game, in, 1: synchronous board clear; overrides move_valid.
- move_valid, in, 1: move request.
- move_pos, in, 4: cell index 0-8, row-major, 0 = top-left.
- move_ready, out, 1: controller can take a move (state IDLE).
- move_accept, out, 1: one-cycle registered pulse; the move was written.
- move_reject, out, 1: one-cycle registered pulse; the move was illegal.
- board, out, 18: board[2i+1:2i] = cell i; 00 empty, 01 X, 10 O; 11 is never written.
- turn, out, 2: code of the player to move.
- scan_busy, out, 1: high while in SCAN.
- game_over, out, 1: high in DONE.
- winner, out, 2: winning player's code, 00 if none.
- draw, out, 1: board full and no winner.

Behaviour:
- Reset (synchronous, active-high), on the next edge:
  - board = 0, turn = FIRST_PLAYER, winner = 00, game_over = draw = 0.
  - move_accept = move_reject = 0, move count = 0, state = IDLE.
  - start_player = FIRST_PLAYER.
- FSM states: IDLE, SCAN, DONE. move_ready = (state == IDLE). scan_busy = (state == SCAN). game_over = (state == DONE).
- Handshake: a move is taken in cycle T when move_valid && move_ready && !new_game.
- Legal move (move_pos ≤ 8 and the cell is empty):
  - At the edge ending T, the cell is written with turn and the move count increments.
  - move_accept = 1 during T+1; state moves to SCAN with line_idx = 0.
- Illegal move (move_pos > 8 or cell occupied):
  - move_reject = 1 during T+1.
  - Board, turn and count are unchanged; state stays IDLE.
- Line table (fixed order, idx: cells):
  - 0: {0,1,2}, 1: {3,4,5}, 2: {6,7,8}
  - 3: {0,3,6}, 4: {1,4,7}, 5: {2,5,8}
  - 6: {0,4,8}, 7: {2,4,6}
- SCAN:
  - Each cycle the three cells of line_idx drive pos_win (pos1, pos2, pos3 in table order).
  - pos_win output nonzero: at that edge, winner = output and state = DONE (early exit).
  - Otherwise line_idx increments.
  - After idx 7 with no win: if count == 9, draw = 1 and state = DONE; else turn toggles (01 <-> 10) and state = IDLE.
- Latency, default build: a win on line k is evaluated in cycle T+1+k, and game_over is first high in T+2+k.
- Latency, no win: move_ready returns in T+9; draw is first high in T+9.
- DONE: holds all outputs. move_ready = 0; move_valid is ignored until new_game or reset.
- new_game, in any state including mid-SCAN, on the next edge:
  - Clear board, count, winner, draw and the pulse outputs; state = IDLE.
  - If ALTERNATE_START = 1, start_player toggles. turn = start_player.
  - Any scan in progress is discarded.
- Reset mid-SCAN: identical to power-up reset; no partial result is reported.
- move_valid while move_ready = 0: ignored and not queued.

Optional Feature:
- Macro: TTT_FAST_SCAN_EN.
- Defined: SCAN visits only the lines that contain the last-played cell, in ascending line_idx order, one cycle each. The list comes from a per-cell package table: 2 lines for edge cells, 3 for corners, 4 for the centre.
  - Win on the j-th visited line (j from 0): game_over first high in T+2+j.
  - No win: move_ready or draw returns in T+1+L, where L is that cell's list length.
- Undefined: the full 8-line scan above.
- Winner and draw results must be identical in both builds.

Decomposition:
- Package ttt_pkg holds:
  - CELL_EMPTY, CELL_X, CELL_O.
  - NUM_CELLS = 9, NUM_LINES = 8.
  - LINE_CELLS[8][3] table.
  - CELL_LINES table with per-cell line count (fast scan).
  - state enum.
- Sub-module ttt_line_mux: combinational, maps board plus line_idx to the three 2-bit cells. Its outputs feed the single pos_win instance.

Test Plan:
- Row win: X0, O3, X1, O4, X2 -> after the 5th accept, winner = 01, game_over = 1 in T+2, move_ready = 0; a further move gets no accept or reject.
- Illegal moves: X4 then O4 -> move_reject in T+1, board unchanged, turn = 10; then move_pos = 9 and 15 -> reject each, state stays IDLE.
- Draw: X0, O1, X2, O4, X3, O5, X7, O6, X8 -> draw = 1 in T+9 after the 9th move, winner = 00, game_over = 1.
- Diagonal latency: X2, O0, X4, O1, X6 -> line 7 wins, game_over first high in T+9 (default) or T+4 (TTT_FAST_SCAN_EN; cell 6 list {2,3,7}).
- new_game asserted in the 3rd SCAN cycle with ALTERNATE_START = 1 -> next cycle board = 0, state IDLE, game_over = 0, turn = 10; repeat with reset -> turn = FIRST_PLAYER.
- Turn/handshake: move_valid held high continuously from IDLE -> exactly one accept per scan, with turn alternating 01, 10, 01 across consecutive accepted moves.
